vga_sync_gen: RTL
=================

# vga_sync_gen

VGA raster timing generator for the snake display path. It sits directly downstream of the pixel-rate clock divider, consuming its one-cycle enable as a pixel strobe. It produces the pixel coordinates, active-low horizontal and vertical sync, a visible-region flag, and line/frame tick pulses. Its outputs feed the pixel renderer and the game-step logic.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

- clk  in  1  system clock; one clock domain only.
- reset  in  1  synchronous, active-high.
- en  in  1  pixel strobe from the upstream divider; state advances only on clk edges where en=1.
- x  out  $clog2(H_TOTAL)  current column, 0..H_TOTAL-1, where H_TOTAL = sum of the four H params.
- y  out  $clog2(V_TOTAL)  current line, 0..V_TOTAL-1, where V_TOTAL = sum of the four V params.
- hsync_n  out  1  horizontal sync, active low.
- vsync_n  out  1  vertical sync, active low.
- visible  out  1  high when x < H_VISIBLE and y < V_VISIBLE.
- line_tick  out  1  one-clk pulse when x wraps to 0.
- frame_tick  out  1  one-clk pulse when (x,y) wraps to (0,0).

## Operation
- Horizontal FSM states, in order: ACTIVE, FRONT, SYNC, BACK.
  - A per-phase down-counter holds the length of the current phase.
  - On en, when the phase counter reaches its last pixel, the FSM moves to the next phase.
  - BACK returns to ACTIVE; that transition wraps x to 0.
- Vertical FSM: identical structure and states. It advances only on en cycles where the horizontal FSM wraps.
- x increments by 1 on each en cycle and wraps from H_TOTAL-1 to 0. y increments on each x wrap and wraps from V_TOTAL-1 to 0.
- hsync_n is 0 exactly while the horizontal FSM is in SYNC. With defaults this is x = 656..751.
- vsync_n is 0 exactly while the vertical FSM is in SYNC. With defaults this is y = 490..491.
- All outputs are flop outputs: no combinational decode reaches a port.
  - x, y, hsync_n, vsync_n and visible are updated in the same edge, so they always describe the same pixel.
- line_tick and frame_tick are 1 in the single clk following the wrap edge, then 0.
  - They do not stay high while en is low.
  - frame_tick implies line_tick in the same cycle.
- Parameter rules:
  - Every timing parameter must be ≥1; a phase of length 1 lasts exactly one en.
  - Defaults give H_TOTAL = 800 and V_TOTAL = 525.

## Timing
- Reset values: x=0, y=0, hsync_n=1, vsync_n=1, visible=1, line_tick=0, frame_tick=0. Both FSMs in ACTIVE with full phase counts.
- reset=1 takes priority over en. Reset mid-line or mid-sync forces the reset values on the next edge, and sync deasserts immediately.
- Latency: an en sampled at edge k is reflected in all outputs after edge k (one clk).
- en=0 freezes all state. Ticks drop to 0 after their one clk.
- en may be continuous (1 every clk) or sparse (1 every N clk). The output sequence versus en count is identical in both cases.
- One frame is exactly H_TOTAL×V_TOTAL en pulses; with defaults, 420000.

## Structure
- Shared package vga_pkg holds:
  - typedef enum sync_phase_t {ACTIVE, FRONT, SYNC, BACK};
  - default 640×480@60 timing constants;
  - H_TOTAL and V_TOTAL derivation functions.
- Sub-module sync_phase_fsm #(VISIBLE, FRONT, SYNC, BACK):
  - inputs clk, reset, step; outputs pos, phase, in_sync, wrap.
  - Instantiated twice: horizontal with step=en; vertical with step=en & h_wrap.
- The top level registers the visible flag and the tick pulses.

## Test plan
- Reset: assert reset 2 clk with en=1 → x=0, y=0, hsync_n=1, vsync_n=1, visible=1, both ticks 0.
- Line wrap: 800 en pulses from reset → x=0, y=1, line_tick=1 for exactly one clk, frame_tick=0.
- Hsync window, continuous en:
  - hsync_n falls on the edge making x=656 and rises on the edge making x=752 (96 en pulses low);
  - visible falls when x=640.
- Frame wrap: 420000 en pulses → x=0, y=0, frame_tick=1 and line_tick=1 for one clk. vsync_n is low for y=490..491 only.
- Sparse en (1 of every 4 clk) and en held low for 100 clk mid-line:
  - outputs frozen while en is low;
  - sequence per en count matches the continuous-en run;
  - ticks last one clk only.
- Reset during SYNC (x=700, y=491) → next edge gives reset values, hsync_n=vsync_n=1. Counting then restarts from (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster timing path:
//   - sync_phase_t : the four phases every scan axis walks through
//   - default 640x480@60 timing constants (pixels for H, lines for V)
//   - helpers deriving line/frame totals and counter widths from the
//     per-phase lengths, so every consumer sizes its counters identically
// -----------------------------------------------------------------------------
package vga_pkg;

    // Phase order is fixed: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } sync_phase_t;

    // Default 640x480@60 horizontal timing, in pixels.
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    // Default 640x480@60 vertical timing, in lines.
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    // Length of one full scan period of an axis.
    function automatic int phase_total(input int visible_len, input int front_len,
                                       input int sync_len, input int back_len);
        return visible_len + front_len + sync_len + back_len;
    endfunction

    // Pixels per line (800 with defaults).
    function automatic int h_total(input int visible_len, input int front_len,
                                   input int sync_len, input int back_len);
        return phase_total(visible_len, front_len, sync_len, back_len);
    endfunction

    // Lines per frame (525 with defaults).
    function automatic int v_total(input int visible_len, input int front_len,
                                   input int sync_len, input int back_len);
        return phase_total(visible_len, front_len, sync_len, back_len);
    endfunction

    // Longest phase of an axis; sizes the per-phase down-counter.
    function automatic int phase_max(input int visible_len, input int front_len,
                                     input int sync_len, input int back_len);
        int m;
        m = visible_len;
        if (front_len > m) m = front_len;
        if (sync_len > m)  m = sync_len;
        if (back_len > m)  m = back_len;
        return m;
    endfunction

    // Bits needed to hold the values 0..max_len inclusive.
    function automatic int count_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/sync_phase_fsm.sv
// -----------------------------------------------------------------------------
// sync_phase_fsm
// One scan axis of the raster: walks ACTIVE -> FRONT -> SYNC -> BACK using a
// per-phase down-counter, and tracks the absolute position along the axis.
// Used once for the horizontal axis (step = pixel strobe) and once for the
// vertical axis (step = pixel strobe on the pixel that ends a line).
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high; returns to ACTIVE, position 0
//   step       in   advance one position on this clock edge
//   pos        out  registered position, 0..TOTAL-1
//   phase      out  registered current phase (sync_phase_t encoding)
//   phase_nxt  out  phase the axis will hold after this edge; lets the parent
//                   register decoded flags in the same edge as pos
//   in_sync    out  registered, high while phase is SYNC
//   wrap       out  high on the step that takes pos from TOTAL-1 back to 0
//                   (already qualified by step; intended for chaining and
//                   for registering into tick pulses)
//
// Every phase length must be at least 1. A phase of length 1 lasts exactly
// one step because the counter is loaded with the length and the phase ends
// on the step taken while the counter reads 1.
// -----------------------------------------------------------------------------
module sync_phase_fsm #(
    parameter int  VISIBLE = vga_pkg::H_VISIBLE_DEF,
    parameter int  FRONT   = vga_pkg::H_FRONT_DEF,
    parameter int  SYNC    = vga_pkg::H_SYNC_DEF,
    parameter int  BACK    = vga_pkg::H_BACK_DEF,
    localparam int POS_W   = $clog2(vga_pkg::phase_total(VISIBLE, FRONT, SYNC, BACK))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [POS_W-1:0] pos,
    output logic [1:0]       phase,
    output logic [1:0]       phase_nxt,
    output logic             in_sync,
    output logic             wrap
);

    localparam int CNT_W = vga_pkg::count_width(vga_pkg::phase_max(VISIBLE, FRONT, SYNC, BACK));

    // Phase lengths pre-sized to the counter so reloads need no width games.
    localparam logic [CNT_W-1:0] LEN_ACTIVE = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] LEN_FRONT  = CNT_W'(FRONT);
    localparam logic [CNT_W-1:0] LEN_SYNC   = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] LEN_BACK   = CNT_W'(BACK);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
    localparam logic [POS_W-1:0] POS_ZERO   = POS_W'(0);

    vga_pkg::sync_phase_t phase_r;
    vga_pkg::sync_phase_t phase_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic [POS_W-1:0]     pos_r;
    logic [POS_W-1:0]     pos_nxt_s;
    logic                 in_sync_r;
    logic                 last_s;
    logic                 wrap_s;

    // Next-state decode: phase sequencing, counter reload/decrement, position.
    always_comb begin
        phase_nxt_s = phase_r;
        cnt_nxt_s   = cnt_r;
        pos_nxt_s   = pos_r;
        last_s      = (cnt_r == CNT_ONE);
        // The only place pos returns to zero is the last step of BACK.
        wrap_s      = step && last_s && (phase_r == vga_pkg::BACK);

        if (step) begin
            if (last_s) begin
                case (phase_r)
                    vga_pkg::ACTIVE: begin
                        phase_nxt_s = vga_pkg::FRONT;
                        cnt_nxt_s   = LEN_FRONT;
                    end
                    vga_pkg::FRONT: begin
                        phase_nxt_s = vga_pkg::SYNC;
                        cnt_nxt_s   = LEN_SYNC;
                    end
                    vga_pkg::SYNC: begin
                        phase_nxt_s = vga_pkg::BACK;
                        cnt_nxt_s   = LEN_BACK;
                    end
                    vga_pkg::BACK: begin
                        phase_nxt_s = vga_pkg::ACTIVE;
                        cnt_nxt_s   = LEN_ACTIVE;
                    end
                    default: begin
                        // Unreachable encoding: resynchronise to line start.
                        phase_nxt_s = vga_pkg::ACTIVE;
                        cnt_nxt_s   = LEN_ACTIVE;
                    end
                endcase
            end else begin
                phase_nxt_s = phase_r;
                cnt_nxt_s   = cnt_r - CNT_ONE;
            end

            if (wrap_s) begin
                pos_nxt_s = POS_ZERO;
            end else begin
                pos_nxt_s = pos_r + POS_ONE;
            end
        end else begin
            phase_nxt_s = phase_r;
            cnt_nxt_s   = cnt_r;
            pos_nxt_s   = pos_r;
        end
    end

    // State registers; reset parks the axis at the start of ACTIVE with a full count.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r   <= vga_pkg::ACTIVE;
            cnt_r     <= LEN_ACTIVE;
            pos_r     <= POS_ZERO;
            in_sync_r <= 1'b0;
        end else begin
            phase_r   <= phase_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pos_r     <= pos_nxt_s;
            in_sync_r <= (phase_nxt_s == vga_pkg::SYNC);
        end
    end

    assign pos       = pos_r;
    assign phase     = phase_r;
    assign phase_nxt = phase_nxt_s;
    assign in_sync   = in_sync_r;
    assign wrap      = wrap_s;

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// VGA raster timing generator. Advances one pixel per cycle of the upstream
// pixel strobe (en) and produces coordinates, active-low syncs, a visible
// flag and line/frame tick pulses for the renderer and game-step logic.
//
// Ports
//   clk         in   system clock (single domain)
//   reset       in   synchronous, active-high; wins over en
//   en          in   pixel strobe; all state holds while en is low
//   x           out  column 0..H_TOTAL-1
//   y           out  line   0..V_TOTAL-1
//   hsync_n     out  low while the horizontal axis is in SYNC
//   vsync_n     out  low while the vertical axis is in SYNC
//   visible     out  high while x < H_VISIBLE and y < V_VISIBLE
//   line_tick   out  one clk high after the edge where x wraps to 0
//   frame_tick  out  one clk high after the edge where (x,y) wraps to (0,0)
//
// All outputs come straight from flops. x/y are the axis position registers;
// the decoded flags are registered from each axis's next phase, so all of
// them change on the same edge and always describe the same pixel.
// Every timing parameter must be at least 1.
// -----------------------------------------------------------------------------
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int  H_VISIBLE = H_VISIBLE_DEF,
    parameter int  H_FRONT   = H_FRONT_DEF,
    parameter int  H_SYNC    = H_SYNC_DEF,
    parameter int  H_BACK    = H_BACK_DEF,
    parameter int  V_VISIBLE = V_VISIBLE_DEF,
    parameter int  V_FRONT   = V_FRONT_DEF,
    parameter int  V_SYNC    = V_SYNC_DEF,
    parameter int  V_BACK    = V_BACK_DEF,
    localparam int H_TOTAL   = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
    localparam int V_TOTAL   = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
    localparam int X_W       = $clog2(H_TOTAL),
    localparam int Y_W       = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           hsync_n,
    output logic           vsync_n,
    output logic           visible,
    output logic           line_tick,
    output logic           frame_tick
);

    logic [X_W-1:0] h_pos_s;
    logic [1:0]     h_phase_s;
    logic [1:0]     h_phase_nxt_s;
    logic           h_in_sync_s;
    logic           h_wrap_s;

    logic [Y_W-1:0] v_pos_s;
    logic [1:0]     v_phase_s;
    logic [1:0]     v_phase_nxt_s;
    logic           v_in_sync_s;
    logic           v_wrap_s;
    logic           v_step_s;

    logic           hsync_n_r;
    logic           vsync_n_r;
    logic           visible_r;
    logic           line_tick_r;
    logic           frame_tick_r;

    // The vertical axis moves one line on the pixel strobe that ends a line.
    assign v_step_s = en && h_wrap_s;

    sync_phase_fsm #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_fsm (
        .clk       (clk),
        .reset     (reset),
        .step      (en),
        .pos       (h_pos_s),
        .phase     (h_phase_s),
        .phase_nxt (h_phase_nxt_s),
        .in_sync   (h_in_sync_s),
        .wrap      (h_wrap_s)
    );

    sync_phase_fsm #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_fsm (
        .clk       (clk),
        .reset     (reset),
        .step      (v_step_s),
        .pos       (v_pos_s),
        .phase     (v_phase_s),
        .phase_nxt (v_phase_nxt_s),
        .in_sync   (v_in_sync_s),
        .wrap      (v_wrap_s)
    );

    // Registered phase/sync views of each axis are not needed at this level;
    // the flags below are decoded from the next phase so they align with x/y.
    logic unused_s;
    assign unused_s = ^{h_phase_s, v_phase_s, h_in_sync_s, v_in_sync_s};

    // Output flags, registered on the same edge that updates x and y.
    // h_wrap_s is already qualified by en, so ticks fall back to 0 on the
    // following edge even when en stays low.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_n_r    <= 1'b1;
            vsync_n_r    <= 1'b1;
            visible_r    <= 1'b1;
            line_tick_r  <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            hsync_n_r    <= (h_phase_nxt_s != SYNC);
            vsync_n_r    <= (v_phase_nxt_s != SYNC);
            visible_r    <= (h_phase_nxt_s == ACTIVE) && (v_phase_nxt_s == ACTIVE);
            line_tick_r  <= h_wrap_s;
            frame_tick_r <= h_wrap_s && v_wrap_s;
        end
    end

    assign x          = h_pos_s;
    assign y          = v_pos_s;
    assign hsync_n    = hsync_n_r;
    assign vsync_n    = vsync_n_r;
    assign visible    = visible_r;
    assign line_tick  = line_tick_r;
    assign frame_tick = frame_tick_r;

endmodule
